// File: rtl/jamma_joy_scanner.sv
`default_nettype none
// ============================================================================
// Module   : jamma_joy_scanner
// Function : Scans the multiplexed JAMMA control bus and debounces each bit.
//            It also merges keyboard overrides and remaps directions for
//            screen rotation.
// Revision : 1.0 - initial release
// ============================================================================
module jamma_joy_scanner #(
    parameter int PLAYERS    = 2,
    parameter int WIDTH      = 8,
    parameter int SETTLE     = 2,
    parameter int DB_SAMPLES = 4,
    localparam int C_SEL_W   = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                       clk_i,
    input  logic                       res_n_i,
    input  logic [WIDTH-1:0]           joy_i,
    output logic [C_SEL_W-1:0]         sel_o,
    input  logic [PLAYERS*WIDTH-1:0]   kbd_n_i,
    input  logic [1:0]                 rotate_i,
    output logic [PLAYERS*WIDTH-1:0]   joy_o,
    output logic [PLAYERS-1:0]         change_o,
    output logic                       frame_o
);

    localparam logic [4:0]         c_SLOT_LAST = 5'(SETTLE + 2);
    localparam logic [C_SEL_W-1:0] c_SEL_LAST  = C_SEL_W'(PLAYERS - 1);
    localparam logic [3:0]         c_DB_LAST   = 4'(DB_SAMPLES - 1);

    logic [WIDTH-1:0]         r_sync1;
    logic [WIDTH-1:0]         r_sync2;
    logic [4:0]               r_slot;
    logic [C_SEL_W-1:0]       r_sel;
    logic                     r_frame_pend;
    logic [PLAYERS*WIDTH-1:0] r_joy;
    logic [PLAYERS-1:0]       r_change;
    logic                     r_frame;

    logic                     w_sample;
    logic [PLAYERS*WIDTH-1:0] w_stable;
    logic [PLAYERS*WIDTH-1:0] w_merged;
    logic [PLAYERS*WIDTH-1:0] w_rot;

    // Direction order in a nibble is {right, left, down, up}.
    function automatic logic [3:0] f_rotate(input logic [3:0] m, input logic [1:0] mode);
        logic [3:0] v;
        case (mode)
            2'd1:    v = {m[0], m[1], m[3], m[2]};
            2'd2:    v = {m[2], m[3], m[0], m[1]};
            2'd3:    v = {m[1], m[0], m[2], m[3]};
            default: v = m;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= joy_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = (r_slot == c_SLOT_LAST);

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_slot       <= '0;
            r_sel        <= '0;
            r_frame_pend <= 1'b0;
        end else begin
            // Delayed one edge so frame_o lines up with the joy_o update.
            r_frame_pend <= w_sample && (r_sel == c_SEL_LAST);
            if (w_sample) begin
                r_slot <= '0;
                r_sel  <= (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
            end else begin
                r_slot <= r_slot + 5'd1;
            end
        end
    end

    assign w_merged = w_stable & kbd_n_i;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        localparam logic [C_SEL_W-1:0] c_P = C_SEL_W'(p);
        logic w_hit;
        assign w_hit = w_sample && (r_sel == c_P);

        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic       r_stable_b;
            logic [3:0] r_cnt_b;

            always_ff @(posedge clk_i or negedge res_n_i) begin
                if (!res_n_i) begin
                    r_stable_b <= 1'b1;
                    r_cnt_b    <= '0;
                end else if (w_hit) begin
                    if (r_sync2[b] == r_stable_b) begin
                        r_cnt_b <= '0;
                    end else if (r_cnt_b == c_DB_LAST) begin
                        r_stable_b <= r_sync2[b];
                        r_cnt_b    <= '0;
                    end else begin
                        r_cnt_b <= r_cnt_b + 4'd1;
                    end
                end
            end

            assign w_stable[p*WIDTH + b] = r_stable_b;
        end

        assign w_rot[p*WIDTH +: 4] = f_rotate(w_merged[p*WIDTH +: 4], rotate_i);

        if (WIDTH > 4) begin : g_pass
            assign w_rot[p*WIDTH + 4 +: WIDTH - 4] = w_merged[p*WIDTH + 4 +: WIDTH - 4];
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            r_joy    <= '1;
            r_change <= '0;
            r_frame  <= 1'b0;
        end else begin
            r_joy   <= w_rot;
            r_frame <= r_frame_pend;
            for (int p = 0; p < PLAYERS; p++) begin
                r_change[p] <= (w_rot[p*WIDTH +: WIDTH] != r_joy[p*WIDTH +: WIDTH]);
            end
        end
    end

    assign sel_o    = r_sel;
    assign joy_o    = r_joy;
    assign change_o = r_change;
    assign frame_o  = r_frame;

endmodule
`default_nettype wire

// File: doc/jamma_joy_scanner.md
# jamma_joy_scanner

Parametrised scanner for the multiplexed JAMMA control bus: drives the external player-select line, samples the shared active-low bus once per player slot, debounces every bit, merges keyboard overrides and applies screen-rotation remapping. It replaces the fixed two-player splitter, debounce and direction-swap logic in each arcade top level. The per-player outputs feed the core's player, joystick and coin inputs directly.

## Interface

**Parameters**
- PLAYERS, 2 — number of multiplexed players, 1..4.
- WIDTH, 8 — bits per player. Bits 0..3 are up, down, left, right; bits 4..WIDTH-1 are not rotated. WIDTH must be at least 4.
- SETTLE, 2 — extra cycles after a select change before the sampled data is used, 0..15.
- DB_SAMPLES, 4 — consecutive differing samples needed to flip a debounced bit, 1..15.

**Ports**
- clk_i, in, 1 — single clock (clk_24 domain).
- res_n_i, in, 1 — reset; asynchronous, active-low.
- joy_i, in, WIDTH — shared JAMMA bus, active-low, asynchronous to clk_i.
- sel_o, out, max(1, clog2(PLAYERS)) — player select to the external multiplexer.
- kbd_n_i, in, PLAYERS*WIDTH — keyboard overrides, active-low, synchronous. A low bit forces the matching output bit low.
- rotate_i, in, 2 — rotation mode: 0 none, 1 quarter-turn, 2 half-turn, 3 inverse quarter-turn.
- joy_o, out, PLAYERS*WIDTH — per-player result, active-low. Player p occupies [p*WIDTH +: WIDTH].
- change_o, out, PLAYERS — one-cycle pulse when player p's slice of joy_o changes.
- frame_o, out, 1 — one-cycle pulse when a full scan of all players completes.

## Operation

- joy_i passes through a 2-flop synchronizer, reset to all ones.
- Slot sequencer:
  - A slot counter runs 0..SETTLE+2. The terminal count is the sample point.
  - At the sample point, the synchronizer output is the debounce sample for player sel_o, and sel_o advances.
  - sel_o counts 0..PLAYERS-1 and then wraps to 0. With PLAYERS=1, sel_o is constant 0.
- Debounce, per bit:
  - Each bit has a stable register (reset 1) and a counter (reset 0).
  - Sample equal to stable: counter is cleared.
  - Sample different from stable and counter = DB_SAMPLES-1: stable takes the sample and the counter is cleared.
  - Otherwise: the counter increments.
  - Only the addressed player's counters update at its sample point.
- Merge: merged = stable AND kbd_n_i. Merging is per cycle and not debounced.
- Rotation applies to bits 0..3 of every player. Outputs are up, down, left, right, each listed as taken from merged:
  - Mode 0: up, down, left, right.
  - Mode 1: left, right, down, up.
  - Mode 2: down, up, right, left.
  - Mode 3: right, left, up, down.
- Output register:
  - joy_o takes the rotated value every cycle.
  - change_o[p] is 1 in the cycle where joy_o slice p differs from its previous value.
- frame_o is 1 in the cycle after the sample point of player PLAYERS-1.

## Timing

**Reset values**
- sel_o = 0
- joy_o = all ones
- change_o = 0
- frame_o = 0
- Slot counter = 0, stable = ones, debounce counters = 0

**Slot timing**
- A slot lasts SETTLE+3 cycles. A frame lasts PLAYERS*(SETTLE+3) cycles.
- Take edge 0 as the edge that sets sel_o. The sample used at edge SETTLE+3 is joy_i as captured at edge SETTLE+1. sel_o changes at edge SETTLE+3.
- After reset release, the first slot is player 0 and its first sample point is edge SETTLE+3.

**Latency**
- Debounced change: the stable register updates at the sample point; joy_o and change_o update one edge later.
- kbd_n_i or rotate_i change: joy_o updates at the next edge.
- Rotation change: change_o pulses if the slice value changes. Debounce state is not reset.

**Boundary behaviour**
- Keyboard low while the pad is released: joy_o is low. Pad state keeps debouncing underneath, and releasing the key reveals the debounced state at once.
- Counter saturation: cannot occur, because the counter clears at DB_SAMPLES-1.
- Reset asserted mid-slot: all state returns to reset values immediately. The scan restarts at player 0 with a full slot.
- A debounced flip on the last player: joy_o, change_o and frame_o all assert in the same cycle.

## Test plan

Defaults apply unless stated: PLAYERS=2, WIDTH=8, SETTLE=2, DB_SAMPLES=4, rotate_i=0, kbd_n_i all ones.

1. **Reset and scan.** Hold res_n_i low, then release it.
   - While low: joy_o=16'hFFFF and sel_o=0.
   - After release: sel_o toggles every 5 cycles (0 for 5, 1 for 5, ...).
   - frame_o pulses once every 10 cycles.
2. **Debounce.** Drive joy_i=8'hEF whenever sel_o=0.
   - joy_o[4] falls 1 cycle after the 4th player-0 sample point.
   - change_o=2'b01 for exactly one cycle.
   - joy_o[15:8] stays 8'hFF.
3. **Glitch rejection.** Hold P1 bit 4 low for 3 player-0 slots, then high.
   - joy_o stays 16'hFFFF.
   - change_o never pulses.
4. **Rotation.** Hold P2 up (bit 0 low at sel_o=1) until debounced.
   - rotate_i=1: joy_o[11]=0 and joy_o[8]=1.
   - rotate_i=2: joy_o[9]=0.
   - rotate_i=3: joy_o[10]=0.
   - Each change appears 1 cycle after rotate_i changes, and each pulses change_o[1].
5. **Keyboard override.** Set kbd_n_i[15]=0 for 1 cycle.
   - joy_o[15]=0 for one cycle, starting 1 cycle after kbd_n_i[15] falls.
   - change_o[1] pulses on the falling edge of joy_o[15] and again when it returns to 1.
6. **Mid-slot reset, with PLAYERS=4 and SETTLE=0.** Assert res_n_i at sel_o=2, slot counter=1.
   - Outputs return to reset values immediately.
   - After release, sel_o runs 0,1,2,3,0 in 3-cycle slots.
